// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 divider core and its host divider_unit.
//   div_state_e : core FSM states
//   div_op_e    : operation encodings, so the host and the core agree on DIV/DIVU/REM/REMU
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

endpackage

// File: rtl/div_step.sv
// Single combinational restoring-division step.
//   rem_i     : partial remainder (magnitude, MW bits)
//   dvd_bit_i : next dividend bit shifted into the remainder
//   dvsr_i    : divisor magnitude (MW bits)
//   rem_o     : next partial remainder
//   q_o       : resolved quotient bit
module div_step #(
  parameter int unsigned MW = 33
) (
  input  logic [MW-1:0] rem_i,
  input  logic          dvd_bit_i,
  input  logic [MW-1:0] dvsr_i,
  output logic [MW-1:0] rem_o,
  output logic          q_o
);

  logic [MW:0] shifted;

  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    q_o     = (shifted >= {1'b0, dvsr_i});
    // When the trial subtraction succeeds the true difference is below the
    // divisor, so the low MW bits of a modulo-2^MW subtract are exact.
    rem_o   = q_o ? (shifted[MW-1:0] - dvsr_i) : shifted[MW-1:0];
  end

endmodule

// File: rtl/radix2_div_core.sv
// Iterative restoring radix-2 divider with valid/ready operand handshake.
//   CLK, nrst           : clock, synchronous active-low reset (overrides aclken)
//   aclken              : clock enable; 0 holds all state and outputs
//   s_axis_tvalid/tready: operand handshake, accepted only in IDLE
//   s_axis_dividend/divisor : WIDTH-bit operands
//   m_axis_dout_tvalid  : one enabled-cycle result pulse
//   m_axis_dout_tdata   : {quotient, remainder}
//   busy                : operation in CALC or FIXUP
module radix2_div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SIGNED         = 0,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic               CLK,
  input  logic               nrst,
  input  logic               aclken,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend,
  input  logic [WIDTH-1:0]   s_axis_divisor,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               busy
);

  localparam int unsigned MW    = WIDTH + 1;
  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MW-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;       // dividend bits shift out, quotient bits shift in
  logic [MW-1:0]      dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;       // original dividend for the special cases
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dvsr_zero_q, dvsr_zero_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] tdata_q, tdata_d;

  logic               sgn;
  logic               a_neg, b_neg;
  logic [MW-1:0]      dvsr_ext;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic [MW-1:0]      rem_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0]   quo_c [BITS_PER_CYCLE+1];

  assign sgn      = (SIGNED != 0);
  assign a_neg    = sgn & s_axis_dividend[WIDTH-1];
  assign b_neg    = sgn & s_axis_divisor[WIDTH-1];
  assign dvsr_ext = {b_neg, s_axis_divisor};

  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic q_bit;
    div_step #(.MW(MW)) u_step (
      .rem_i    (rem_c[i]),
      .dvd_bit_i(quo_c[i][WIDTH-1]),
      .dvsr_i   (dvsr_q),
      .rem_o    (rem_c[i+1]),
      .q_o      (q_bit)
    );
    assign quo_c[i+1] = {quo_c[i][WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dvd_d       = dvd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dvsr_zero_d = dvsr_zero_q;
    ovf_d       = ovf_q;
    tdata_d     = tdata_q;
    quo_fix     = neg_quo_q ? ('0 - quo_q) : quo_q;
    rem_fix     = neg_rem_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          dvd_d       = s_axis_dividend;
          quo_d       = a_neg ? ('0 - s_axis_dividend) : s_axis_dividend;
          dvsr_d      = b_neg ? ('0 - dvsr_ext) : dvsr_ext;
          neg_quo_d   = a_neg ^ b_neg;
          neg_rem_d   = a_neg;
          dvsr_zero_d = (s_axis_divisor == '0);
          ovf_d       = sgn && (s_axis_dividend == MIN_NEG) && (s_axis_divisor == '1);
          rem_d       = '0;
          cnt_d       = CW'(STEPS);
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        // The counter is checked before stepping, so the empty-counter edge
        // is the CALC->FIXUP transition.
        if (cnt_q == '0) begin
          state_d = ST_FIXUP;
        end else begin
          rem_d = rem_c[BITS_PER_CYCLE];
          quo_d = quo_c[BITS_PER_CYCLE];
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIXUP: begin
        if (dvsr_zero_q) begin
          quo_fix = '1;
          rem_fix = dvd_q;
        end else if (ovf_q) begin
          quo_fix = dvd_q;
          rem_fix = '0;
        end
        tdata_d = {quo_fix, rem_fix};
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dvd_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvsr_zero_q <= 1'b0;
      ovf_q       <= 1'b0;
      tdata_q     <= '0;
    end else if (aclken) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      dvd_q       <= dvd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dvsr_zero_q <= dvsr_zero_d;
      ovf_q       <= ovf_d;
      tdata_q     <= tdata_d;
    end
  end

  always_comb begin
    s_axis_tready      = (state_q == ST_IDLE);
    m_axis_dout_tvalid = (state_q == ST_DONE);
    busy               = (state_q == ST_CALC) || (state_q == ST_FIXUP);
    m_axis_dout_tdata  = tdata_q;
  end

endmodule

// File: tb/tb_radix2_div_core.sv
module tb_radix2_div_core;

  logic        CLK = 1'b0;
  logic        nrst;
  logic        aclken;
  logic        s_tvalid;
  logic [31:0] dividend;
  logic [31:0] divisor;

  logic        tready_u, tvalid_u, busy_u;
  logic [63:0] tdata_u;
  logic        tready_s, tvalid_s, busy_s;
  logic [63:0] tdata_s;

  int n_chk = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  radix2_div_core #(.WIDTH(32), .SIGNED(0), .BITS_PER_CYCLE(1)) u_dut_u (
    .CLK               (CLK),
    .nrst              (nrst),
    .aclken            (aclken),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (tready_u),
    .s_axis_dividend   (dividend),
    .s_axis_divisor    (divisor),
    .m_axis_dout_tvalid(tvalid_u),
    .m_axis_dout_tdata (tdata_u),
    .busy              (busy_u)
  );

  radix2_div_core #(.WIDTH(32), .SIGNED(1), .BITS_PER_CYCLE(1)) u_dut_s (
    .CLK               (CLK),
    .nrst              (nrst),
    .aclken            (aclken),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (tready_s),
    .s_axis_dividend   (dividend),
    .s_axis_divisor    (divisor),
    .m_axis_dout_tvalid(tvalid_s),
    .m_axis_dout_tdata (tdata_s),
    .busy              (busy_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation to both cores (unsigned and signed) and checks
  // latency, handshake and both results. stall_at>=0 disables aclken for
  // five edges starting after that edge; done_stall freezes the DONE pulse.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input bit done_stall,
                        input logic [63:0] exp_u, input logic [63:0] exp_s);
    int   lat;
    int   stalls;
    logic saw_ready;
    logic got;
    @(negedge CLK);
    dividend = a;
    divisor  = b;
    s_tvalid = 1'b1;
    aclken   = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    lat = 0; stalls = 0; saw_ready = 1'b0; got = 1'b0;
    while (!got && lat < 200) begin
      // Foreign operands offered mid-operation must be ignored.
      s_tvalid = (lat < 20);
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'h0000_0003;
      if (stall_at >= 0 && lat >= stall_at && lat < stall_at + 5) begin
        aclken = 1'b0;
        stalls++;
      end else begin
        aclken = 1'b1;
      end
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (lat == 5) chk({tag, "_busy"}, 64'(busy_u & busy_s), 64'd1);
      if (tvalid_u) got = 1'b1;
      else if (tready_u || tready_s) saw_ready = 1'b1;
    end
    s_tvalid = 1'b0;
    chk({tag, "_lat"},     64'(lat), 64'(34 + stalls));
    chk({tag, "_vld_s"},   64'(tvalid_s), 64'd1);
    chk({tag, "_rdy_low"}, 64'(saw_ready), 64'd0);
    chk({tag, "_data_u"},  tdata_u, exp_u);
    chk({tag, "_data_s"},  tdata_s, exp_s);
    if (done_stall) begin
      aclken = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, "_vld_hold"}, 64'(tvalid_u & tvalid_s), 64'd1);
      end
      aclken = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_pulse_end"}, 64'(tvalid_u | tvalid_s), 64'd0);
    chk({tag, "_rdy_back"},  64'(tready_u & tready_s), 64'd1);
    chk({tag, "_hold_u"},    tdata_u, exp_u);
  endtask

  initial begin
    logic saw_vld;
    nrst     = 1'b0;
    aclken   = 1'b1;
    s_tvalid = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rdy",  64'(tready_u & tready_s), 64'd1);
    chk("rst_vld",  64'(tvalid_u | tvalid_s), 64'd0);
    chk("rst_busy", 64'(busy_u | busy_s), 64'd0);
    chk("rst_data", tdata_u | tdata_s, 64'd0);
    nrst = 1'b1;

    run_op("d100_7", 32'd100, 32'd7, -1, 1'b0,
           {32'd14, 32'd2}, {32'd14, 32'd2});
    run_op("neg7_2", 32'hFFFF_FFF9, 32'd2, -1, 1'b0,
           {32'h7FFF_FFFC, 32'h0000_0001}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run_op("divz", 32'h1234_5678, 32'd0, -1, 1'b0,
           {32'hFFFF_FFFF, 32'h1234_5678}, {32'hFFFF_FFFF, 32'h1234_5678});
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0,
           {32'h0000_0000, 32'h8000_0000}, {32'h8000_0000, 32'h0000_0000});
    run_op("d100_neg7", 32'd100, 32'hFFFF_FFF9, -1, 1'b0,
           {32'h0000_0000, 32'd100}, {32'hFFFF_FFF2, 32'h0000_0002});
    run_op("stall", 32'hFFFF_FF9C, 32'd7, 10, 1'b1,
           {32'h2492_4916, 32'h0000_0002}, {32'hFFFF_FFF2, 32'hFFFF_FFFE});

    // Reset in the middle of CALC abandons the operation.
    @(negedge CLK);
    dividend = 32'd1000;
    divisor  = 32'd3;
    s_tvalid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    s_tvalid = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    nrst = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nrst = 1'b1;
    saw_vld = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (tvalid_u || tvalid_s) saw_vld = 1'b1;
    end
    chk("mid_rst_novld", 64'(saw_vld), 64'd0);
    chk("mid_rst_rdy",   64'(tready_u & tready_s), 64'd1);
    chk("mid_rst_data",  tdata_u | tdata_s, 64'd0);

    run_op("d50_5", 32'd50, 32'd5, -1, 1'b0,
           {32'd10, 32'd0}, {32'd10, 32'd0});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
